pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pipe_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
`default_nettype none
//============================================================================
// Module   : pipe_sequencer
// Brief    : Pipeline control sequencer. Produces per-stage write enables and
//            flush controls from hazard, branch, memory-busy and halt inputs.
//            Controls are combinational from the registered state and the
//            current inputs, so a stall takes effect in the same cycle.
//            Optional macro PIPE_PERF_CNT_EN compiles in the saturating
//            stall_cycles / flush_count performance counters; without it
//            both outputs are tied to zero.
// Revision : 1.0 - initial release
//============================================================================
module pipe_sequencer #(
    parameter int STALL_MAX    = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic        br_taken,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        resume,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic        stall_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam int c_STALL_W = $clog2(STALL_MAX + 1) + 1;
    localparam int c_DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [c_STALL_W-1:0] c_STALL_LIM  = c_STALL_W'(STALL_MAX + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);

    localparam logic [1:0] c_S_RUN    = 2'd0;
    localparam logic [1:0] c_S_FLUSH  = 2'd1;
    localparam logic [1:0] c_S_DRAIN  = 2'd2;
    localparam logic [1:0] c_S_HALTED = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [c_STALL_W-1:0] w_stall_cnt_nxt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [c_DRAIN_W-1:0] w_drain_cnt_nxt;
    logic                 r_stall_err;
    logic                 w_hazard_stall;
    logic                 w_frozen;

    // Memory-busy freezes every state except HALTED, where it is ignored
    assign w_frozen  = mem_busy && (r_state != c_S_HALTED);
    assign halted    = (r_state == c_S_HALTED);
    assign stall_err = r_stall_err;

    // Next-state, stage controls and drain-counter update
    always_comb begin
        w_next_state    = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_hazard_stall  = 1'b0;
        pc_we           = 1'b0;
        if_id_we        = 1'b0;
        id_ex_we        = 1'b0;
        ex_mem_we       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        case (r_state)
            c_S_RUN, c_S_FLUSH: begin
                if (mem_busy) begin
                    // whole pipe frozen; defaults already hold everything
                end else if (br_taken) begin
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    id_ex_we     = 1'b1;
                    ex_mem_we    = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    w_next_state = c_S_FLUSH;
                end else if (r_state == c_S_FLUSH) begin
                    // Stages already hold bubbles, so hazard/halt wait a cycle
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    id_ex_we     = 1'b1;
                    ex_mem_we    = 1'b1;
                    w_next_state = c_S_RUN;
                end else if (hazard) begin
                    id_ex_we       = 1'b1;
                    id_ex_flush    = 1'b1;
                    ex_mem_we      = 1'b1;
                    w_hazard_stall = 1'b1;
                end else if (halt_req) begin
                    if_id_we        = 1'b1;
                    id_ex_we        = 1'b1;
                    ex_mem_we       = 1'b1;
                    if_id_flush     = 1'b1;
                    w_next_state    = c_S_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                end else begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    id_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                end
            end
            c_S_DRAIN: begin
                if (!mem_busy) begin
                    if_id_we        = 1'b1;
                    id_ex_we        = 1'b1;
                    ex_mem_we       = 1'b1;
                    if_id_flush     = 1'b1;
                    w_drain_cnt_nxt = r_drain_cnt - c_DRAIN_ONE;
                    if (r_drain_cnt <= c_DRAIN_ONE) begin
                        w_next_state    = c_S_HALTED;
                        w_drain_cnt_nxt = '0;
                    end
                end
            end
            c_S_HALTED: begin
                if (resume) begin
                    w_next_state = c_S_RUN;
                end
            end
            default: begin
                w_next_state = c_S_RUN;
            end
        endcase
    end

    // Consecutive-hazard run length: hold while frozen, saturate at the limit
    always_comb begin
        w_stall_cnt_nxt = '0;
        if (w_frozen) begin
            w_stall_cnt_nxt = r_stall_cnt;
        end else if (w_hazard_stall) begin
            w_stall_cnt_nxt = (r_stall_cnt == c_STALL_LIM) ? r_stall_cnt
                                                          : r_stall_cnt + 1'b1;
        end
    end

    // State, counters and sticky stall error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_RUN;
            r_stall_cnt <= '0;
            r_drain_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_stall_cnt_nxt == c_STALL_LIM) begin
                r_stall_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    logic        w_flush_evt;

    assign w_flush_evt = ((r_state == c_S_RUN) || (r_state == c_S_FLUSH))
                         && !mem_busy && br_taken;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_we && (r_state != c_S_HALTED) && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_flush_evt && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_pipe_sequencer
// Brief    : Directed self-checking bench for pipe_sequencer (STALL_MAX=4,
//            DRAIN_CYCLES=3). Counter expectations follow PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
//============================================================================
module tb_pipe_sequencer;

    logic        clk;
    logic        rst_n;
    logic        hazard, br_taken, mem_busy, halt_req, resume;
    logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic        if_id_flush, id_ex_flush, halted, stall_err;
    logic [15:0] stall_cycles, flush_count;
    logic [5:0]  ctl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush}
    localparam logic [5:0] c_ALL    = 6'b111100;
    localparam logic [5:0] c_FREEZE = 6'b000000;
    localparam logic [5:0] c_HAZ    = 6'b001101;
    localparam logic [5:0] c_BR     = 6'b111111;
    localparam logic [5:0] c_DRN    = 6'b011110;

    int n_chk  = 0;
    int n_fail = 0;

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush};

    pipe_sequencer #(.STALL_MAX(4), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard(hazard), .br_taken(br_taken), .mem_busy(mem_busy),
        .halt_req(halt_req), .resume(resume),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .stall_err(stall_err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic h, input logic b, input logic m,
                          input logic hr, input logic rs);
        hazard = h; br_taken = b; mem_busy = m; halt_req = hr; resume = rs;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #2;
        n_chk++;
        if (ctl !== c_ALL || halted !== 1'b0 || stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ctl=%b halted=%b err=%b want ctl=%b halted=0 err=0",
                     ctl, halted, stall_err, c_ALL);
        end
        n_chk++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (ctl !== c_ALL || halted !== 1'b0 || stall_err !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cyc%0d: got ctl=%b halted=%b err=%b want ctl=%b 0 0",
                         i, ctl, halted, stall_err, c_ALL);
            end
            step();
        end
    endtask

    task automatic test_hazard_short();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 0, 0);
            @(negedge clk);
            n_chk++;
            if (ctl !== c_HAZ) begin
                n_fail++;
                $display("FAIL hazard_ctl cyc%0d: got %b want %b", i, ctl, c_HAZ);
            end
            step();
        end
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (ctl !== c_ALL || stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_release: got ctl=%b err=%b want %b err=0", ctl, stall_err, c_ALL);
        end
        n_chk++;
        if (stall_cycles !== (c_PERF ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL hazard_stall_cycles: got %0d want %0d", stall_cycles, c_PERF ? 2 : 0);
        end
        step();
    endtask

    task automatic test_stall_err();
        do_reset();
        // Four hazards then a break: exactly at the limit, no error
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_err_4: got %b want 0", stall_err);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0);
            @(negedge clk);
            n_chk++;
            if (stall_err !== 1'b0 || ctl !== c_HAZ) begin
                n_fail++;
                $display("FAIL stall_err_early cyc%0d: got err=%b ctl=%b want 0 %b",
                         i, stall_err, ctl, c_HAZ);
            end
            step();
        end
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (stall_err !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_err_sticky cyc%0d: got %b want 1", i, stall_err);
            end
            step();
        end
        n_chk++;
        if (stall_cycles !== (c_PERF ? 16'd9 : 16'd0)) begin
            n_fail++;
            $display("FAIL stall_err_cycles: got %0d want %0d", stall_cycles, c_PERF ? 9 : 0);
        end
    endtask

    task automatic test_branch();
        logic [5:0] exp_ctl [7];
        logic       vh [7];
        logic       vb [7];
        logic       vhr[7];
        logic       vm [7];
        exp_ctl = '{c_BR, c_ALL, c_ALL, c_FREEZE, c_BR, c_BR, c_ALL};
        vh      = '{1, 1, 0, 0, 0, 0, 0};
        vb      = '{1, 0, 0, 1, 1, 1, 0};
        vhr     = '{1, 1, 0, 0, 0, 0, 0};
        vm      = '{0, 0, 0, 1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(vh[i], vb[i], vm[i], vhr[i], 0);
            @(negedge clk);
            n_chk++;
            if (ctl !== exp_ctl[i]) begin
                n_fail++;
                $display("FAIL branch_ctl cyc%0d: got %b want %b", i, ctl, exp_ctl[i]);
            end
            if (i == 2) begin
                n_chk++;
                if (flush_count !== (c_PERF ? 16'd1 : 16'd0)) begin
                    n_fail++;
                    $display("FAIL branch_flush_count1: got %0d want %0d",
                             flush_count, c_PERF ? 1 : 0);
                end
            end
            step();
        end
        // FLUSH is over: a hazard now stalls normally
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (ctl !== c_HAZ || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_after_flush: got ctl=%b halted=%b want %b 0", ctl, halted, c_HAZ);
        end
        n_chk++;
        if (flush_count !== (c_PERF ? 16'd3 : 16'd0)) begin
            n_fail++;
            $display("FAIL branch_flush_count3: got %0d want %0d", flush_count, c_PERF ? 3 : 0);
        end
        step();
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_drain_halt();
        logic [5:0] exp_ctl [6];
        logic       vm [6];
        logic       vb [6];
        logic       vhr[6];
        exp_ctl = '{c_DRN, c_DRN, c_FREEZE, c_FREEZE, c_DRN, c_DRN};
        vhr     = '{1, 0, 0, 0, 0, 0};
        vm      = '{0, 0, 1, 1, 0, 0};
        vb      = '{0, 1, 1, 0, 0, 1};
        do_reset();
        // resume outside HALTED does nothing
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++;
        if (ctl !== c_ALL || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_in_run: got ctl=%b halted=%b want %b 0", ctl, halted, c_ALL);
        end
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(0, vb[i], vm[i], vhr[i], 0);
            @(negedge clk);
            n_chk++;
            if (ctl !== exp_ctl[i] || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_ctl cyc%0d: got ctl=%b halted=%b want %b 0",
                         i, ctl, halted, exp_ctl[i]);
            end
            step();
        end
        set_in(0, 0, 1, 0, 0);
        @(negedge clk);
        n_chk++;
        if (ctl !== c_FREEZE || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halted_entry: got ctl=%b halted=%b want %b 1", ctl, halted, c_FREEZE);
        end
        n_chk++;
        if (stall_cycles !== (c_PERF ? 16'd6 : 16'd0) || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL drain_counters: got %0d/%0d want %0d/0",
                     stall_cycles, flush_count, c_PERF ? 6 : 0);
        end
        step();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        n_chk++;
        if (halted !== 1'b1 || ctl !== c_FREEZE) begin
            n_fail++;
            $display("FAIL halted_resume_cycle: got halted=%b ctl=%b want 1 %b", halted, ctl, c_FREEZE);
        end
        step();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (halted !== 1'b0 || ctl !== c_ALL) begin
            n_fail++;
            $display("FAIL after_resume: got halted=%b ctl=%b want 0 %b", halted, ctl, c_ALL);
        end
        n_chk++;
        if (stall_cycles !== (c_PERF ? 16'd6 : 16'd0)) begin
            n_fail++;
            $display("FAIL halted_no_count: got %0d want %0d", stall_cycles, c_PERF ? 6 : 0);
        end
        step();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0);
            step();
        end
        set_in(0, 0, 0, 1, 0);
        step();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (ctl !== c_DRN || stall_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_drain: got ctl=%b err=%b want %b 1", ctl, stall_err, c_DRN);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ctl !== c_ALL || halted !== 1'b0 || stall_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got ctl=%b halted=%b err=%b want %b 0 0",
                     ctl, halted, stall_err, c_ALL);
        end
        n_chk++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (ctl !== c_ALL || halted !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_run cyc%0d: got ctl=%b halted=%b want %b 0",
                         i, ctl, halted, c_ALL);
            end
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        test_reset();
        test_hazard_short();
        test_stall_err();
        test_branch();
        test_drain_halt();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
